// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, datapath
// select encodings and data-processing command codes.
package mc_control_fsm_pkg;

  // Multicycle FSM states; UNDEF is only reachable when MC_UNDEF_TRAP_EN is defined.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNDEF    = 4'd10
  } state_t;

  // Instruction classes from Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALUControl encodings
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // ImmSrc encodings (extender mode)
  localparam logic [1:0] IMM_IMM8  = 2'b00;
  localparam logic [1:0] IMM_IMM12 = 2'b01;
  localparam logic [1:0] IMM_IMM24 = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  // Data-processing cmd field values (Funct[4:1])
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Arithmetic commands are the only ones that produce meaningful C/V flags.
  function automatic logic cmd_sets_cv(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the data-processing cmd and S bit to ALUControl/FlagW.
// When alu_op is low the ALU is used for address/PC arithmetic and is forced to ADD.
module mc_control_fsm_alu_decoder
  import mc_control_fsm_pkg::*;
(
  input  logic [4:0] funct,
  input  logic       alu_op,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w
);

  logic [3:0] cmd_s;
  logic       s_bit_s;

  assign cmd_s   = funct[4:1];
  assign s_bit_s = funct[0];

  // Command decode and flag write enables, active only during execute states.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    if (alu_op) begin
      case (cmd_s)
        CMD_ADD: alu_control = ALU_ADD;
        CMD_SUB: alu_control = ALU_SUB;
        CMD_AND: alu_control = ALU_AND;
        CMD_ORR: alu_control = ALU_ORR;
        default: alu_control = ALU_ADD;
      endcase
      flag_w = {s_bit_s, s_bit_s & cmd_sets_cv(cmd_s)};
    end else begin
      alu_control = ALU_ADD;
      flag_w      = 2'b00;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle ARM-subset datapath.
// State is the only register; all other outputs decode State, Op and Funct.
// Optional macro MC_UNDEF_TRAP_EN: Op=11 traps into an absorbing UNDEF state
// and adds the Undef output; otherwise Op=11 returns to FETCH with no writes.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int STATE_W = 4
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         FlagW,
  output logic [STATE_W-1:0] State
`ifdef MC_UNDEF_TRAP_EN
  ,
  output logic               Undef
`endif
);

  logic [STATE_W-1:0] state_r;
  logic [STATE_W-1:0] state_next_s;
  logic               alu_op_s;

  // State register; reset aborts any instruction and restarts at FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= STATE_W'(S_FETCH);
    end else begin
      state_r <= state_next_s;
    end
  end

  assign State = state_r;

  // Next-state logic and per-state datapath enables/selects.
  always_comb begin
    state_next_s = STATE_W'(S_FETCH);
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    ResultSrc    = RES_ALUOUT;
    NextPC       = 1'b0;
    RegW         = 1'b0;
    MemW         = 1'b0;
    Branch       = 1'b0;
`ifdef MC_UNDEF_TRAP_EN
    Undef        = 1'b0;
`endif
    case (state_r)
      STATE_W'(S_FETCH): begin
        IRWrite      = 1'b1;
        NextPC       = 1'b1;
        ALUSrcA      = 1'b1;
        ALUSrcB      = SRCB_FOUR;
        ResultSrc    = RES_ALURESULT;
        state_next_s = STATE_W'(S_DECODE);
      end
      STATE_W'(S_DECODE): begin
        // PC+8 computed here for branch/PC-relative reads
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_DP: begin
            if (Funct[5]) begin
              state_next_s = STATE_W'(S_EXECUTEI);
            end else begin
              state_next_s = STATE_W'(S_EXECUTER);
            end
          end
          OP_MEM:  state_next_s = STATE_W'(S_MEMADR);
          OP_BR:   state_next_s = STATE_W'(S_BRANCH);
`ifdef MC_UNDEF_TRAP_EN
          default: state_next_s = STATE_W'(S_UNDEF);
`else
          default: state_next_s = STATE_W'(S_FETCH);
`endif
        endcase
      end
      STATE_W'(S_MEMADR): begin
        ALUSrcB = SRCB_EXTIMM;
        if (Funct[0]) begin
          state_next_s = STATE_W'(S_MEMRD);
        end else begin
          state_next_s = STATE_W'(S_MEMWR);
        end
      end
      STATE_W'(S_MEMRD): begin
        AdrSrc       = 1'b1;
        state_next_s = STATE_W'(S_MEMWB);
      end
      STATE_W'(S_MEMWB): begin
        ResultSrc    = RES_DATA;
        RegW         = 1'b1;
        state_next_s = STATE_W'(S_FETCH);
      end
      STATE_W'(S_MEMWR): begin
        AdrSrc       = 1'b1;
        MemW         = 1'b1;
        state_next_s = STATE_W'(S_FETCH);
      end
      STATE_W'(S_EXECUTER): begin
        ALUSrcB      = SRCB_REG;
        state_next_s = STATE_W'(S_ALUWB);
      end
      STATE_W'(S_EXECUTEI): begin
        ALUSrcB      = SRCB_EXTIMM;
        state_next_s = STATE_W'(S_ALUWB);
      end
      STATE_W'(S_ALUWB): begin
        ResultSrc    = RES_ALUOUT;
        RegW         = 1'b1;
        state_next_s = STATE_W'(S_FETCH);
      end
      STATE_W'(S_BRANCH): begin
        ALUSrcB      = SRCB_EXTIMM;
        ResultSrc    = RES_ALURESULT;
        Branch       = 1'b1;
        state_next_s = STATE_W'(S_FETCH);
      end
`ifdef MC_UNDEF_TRAP_EN
      STATE_W'(S_UNDEF): begin
        Undef        = 1'b1;
        state_next_s = STATE_W'(S_UNDEF);
      end
`endif
      default: begin
        state_next_s = STATE_W'(S_FETCH);
      end
    endcase
  end

  // Decode-side selects for the extender and register-file read ports.
  always_comb begin
    ImmSrc = Op;
    case (Op)
      OP_DP:   ImmSrc = IMM_IMM8;
      OP_MEM:  ImmSrc = IMM_IMM12;
      OP_BR:   ImmSrc = IMM_IMM24;
      default: ImmSrc = Op;
    endcase
    RegSrc = {(Op == OP_MEM), (Op == OP_BR)};
  end

  assign alu_op_s = (state_r == STATE_W'(S_EXECUTER)) ||
                    (state_r == STATE_W'(S_EXECUTEI));

  mc_control_fsm_alu_decoder u_alu_decoder (
    .funct       (Funct[4:0]),
    .alu_op      (alu_op_s),
    .alu_control (ALUControl),
    .flag_w      (FlagW)
  );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm. Each instruction is expanded into
// its expected state walk, and every cycle is compared against a reference
// output table derived from the per-state behaviour.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, FlagW;
  logic [3:0] State;
`ifdef MC_UNDEF_TRAP_EN
  logic       Undef;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int plan_q[$];

  // Reference state numbers
  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4,
                 MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9, UNDEF = 10;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .FlagW(FlagW), .State(State)
`ifdef MC_UNDEF_TRAP_EN
    , .Undef(Undef)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, tests=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // Expected outputs packed as
  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ImmSrc,RegSrc,ALUControl,FlagW}
  function automatic logic [19:0] model_out(int st, logic [1:0] op, logic [5:0] f);
    logic ir = 1'b0, adr = 1'b0, asa = 1'b0, npc = 1'b0, rw = 1'b0, mw = 1'b0, br = 1'b0;
    logic [1:0] asb = 2'd0, rs = 2'd0, aluc = 2'd0, fw = 2'd0;
    int cmd;
    cmd = int'(f[4:1]);
    if (st == FETCH)  begin ir = 1'b1; npc = 1'b1; asa = 1'b1; asb = 2'd2; rs = 2'd2; end
    if (st == DECODE) begin asa = 1'b1; asb = 2'd2; rs = 2'd2; end
    if (st == MEMADR) asb = 2'd1;
    if (st == MEMRD)  adr = 1'b1;
    if (st == MEMWB)  begin rs = 2'd1; rw = 1'b1; end
    if (st == MEMWR)  begin adr = 1'b1; mw = 1'b1; end
    if (st == EXECI)  asb = 2'd1;
    if (st == ALUWB)  rw = 1'b1;
    if (st == BRANCH) begin asb = 2'd1; rs = 2'd2; br = 1'b1; end
    if (st == EXECR || st == EXECI) begin
      aluc = (cmd == 4) ? 2'd0 : (cmd == 2) ? 2'd1 : (cmd == 0) ? 2'd2 : (cmd == 12) ? 2'd3 : 2'd0;
      fw   = {f[0], f[0] & ((cmd == 4) || (cmd == 2))};
    end
    return {ir, adr, asa, asb, rs, npc, rw, mw, br, op, (op == 2'b01), (op == 2'b10), aluc, fw};
  endfunction

  // Expected state walk of one instruction, starting at FETCH.
  task automatic build_plan(input logic [1:0] op, input logic [5:0] f);
    plan_q.delete();
    plan_q.push_back(FETCH);
    plan_q.push_back(DECODE);
    if (op == 2'b00) begin
      plan_q.push_back(f[5] ? EXECI : EXECR);
      plan_q.push_back(ALUWB);
    end else if (op == 2'b01) begin
      plan_q.push_back(MEMADR);
      if (f[0]) begin
        plan_q.push_back(MEMRD);
        plan_q.push_back(MEMWB);
      end else begin
        plan_q.push_back(MEMWR);
      end
    end else if (op == 2'b10) begin
      plan_q.push_back(BRANCH);
    end else begin
`ifdef MC_UNDEF_TRAP_EN
      plan_q.push_back(UNDEF);
`endif
    end
  endtask

  // Runs one instruction from FETCH, checking State and all outputs each cycle.
  // Op/Funct carry junk during FETCH to show they are ignored there.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f);
    logic [19:0] obs, expv;
    logic [1:0]  cur_op;
    logic [5:0]  cur_f;
    build_plan(op, f);
    foreach (plan_q[i]) begin
      if (i == 0) begin
        cur_op = 2'($urandom_range(3, 0));
        cur_f  = 6'($urandom_range(63, 0));
      end else begin
        cur_op = op;
        cur_f  = f;
      end
      Op = cur_op;
      Funct = cur_f;
      #1;
      obs  = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch,
              ImmSrc, RegSrc, ALUControl, FlagW};
      expv = model_out(plan_q[i], cur_op, cur_f);
      tests_run++;
      if (State !== 4'(plan_q[i])) begin
        tests_failed++;
        $display("FAIL state op=%b funct=%b step=%0d: got %0d want %0d", op, f, i, State, plan_q[i]);
      end
      tests_run++;
      if (obs !== expv) begin
        tests_failed++;
        $display("FAIL outputs op=%b funct=%b step=%0d: got %b want %b", op, f, i, obs, expv);
      end
`ifdef MC_UNDEF_TRAP_EN
      tests_run++;
      if (Undef !== (plan_q[i] == UNDEF)) begin
        tests_failed++;
        $display("FAIL undef_flag step=%0d: got %b want %b", i, Undef, (plan_q[i] == UNDEF));
      end
`endif
      Op = op;
      Funct = f;
      @(posedge clk); #1;
    end
    if (plan_q[plan_q.size() - 1] != UNDEF) begin
      tests_run++;
      if (State !== 4'(FETCH)) begin
        tests_failed++;
        $display("FAIL return_to_fetch op=%b funct=%b: got %0d want %0d", op, f, State, FETCH);
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    Op = 2'($urandom_range(3, 0));
    Funct = 6'($urandom_range(63, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch,
           ImmSrc, RegSrc, ALUControl, FlagW};
    tests_run++;
    if (State !== 4'(FETCH)) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d want %0d", State, FETCH);
    end
    tests_run++;
    if (obs !== model_out(FETCH, Op, Funct)) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want %b", obs, model_out(FETCH, Op, Funct));
    end
    reset = 1'b0;
  endtask

  // Directed test-plan instructions.
  task automatic test_directed();
    run_instr(2'b00, 6'b101000);  // ADD imm
    run_instr(2'b00, 6'b000101);  // SUBS reg
    run_instr(2'b00, 6'b011001);  // ORRS reg
    run_instr(2'b00, 6'b000001);  // ANDS reg
    run_instr(2'b01, 6'b011001);  // LDR
    run_instr(2'b01, 6'b011000);  // STR
    run_instr(2'b10, 6'b100000);  // B
  endtask

  // Cycle count from FETCH back to FETCH, against fixed instruction latencies.
  task automatic test_latency();
    logic [1:0] ops [4] = '{2'b10, 2'b00, 2'b01, 2'b01};
    logic [5:0] fns [4] = '{6'b000000, 6'b000100, 6'b011000, 6'b011001};
    int         lat [4] = '{3, 4, 4, 5};
    int n;
    for (int k = 0; k < 4; k++) begin
      Op = ops[k];
      Funct = fns[k];
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (State !== 4'(FETCH) && n < 12);
      tests_run++;
      if (n != lat[k]) begin
        tests_failed++;
        $display("FAIL latency op=%b: got %0d cycles want %0d", ops[k], n, lat[k]);
      end
    end
  endtask

  // Reset during MEMWR, then an illegal opcode.
  task automatic test_reset_abort();
    Op = 2'b01;
    Funct = 6'b011000;
    repeat (3) begin
      @(posedge clk); #1;
    end
    tests_run++;
    if (State !== 4'(MEMWR) || MemW !== 1'b1) begin
      tests_failed++;
      $display("FAIL reach_memwr: got state %0d memw %b want %0d 1", State, MemW, MEMWR);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (State !== 4'(FETCH) || MemW !== 1'b0 || RegW !== 1'b0 || Branch !== 1'b0 || IRWrite !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_reset: got state %0d memw %b regw %b br %b irw %b want 0 0 0 0 1",
               State, MemW, RegW, Branch, IRWrite);
    end
    run_instr(2'b11, 6'($urandom_range(63, 0)));
`ifdef MC_UNDEF_TRAP_EN
    for (int c = 0; c < 3; c++) begin
      Op = 2'($urandom_range(3, 0));
      Funct = 6'($urandom_range(63, 0));
      #1;
      tests_run++;
      if (State !== 4'(UNDEF) || Undef !== 1'b1 || RegW !== 1'b0 || MemW !== 1'b0 ||
          IRWrite !== 1'b0 || NextPC !== 1'b0 || Branch !== 1'b0) begin
        tests_failed++;
        $display("FAIL undef_hold cycle=%0d: got state %0d undef %b", c, State, Undef);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (State !== 4'(FETCH)) begin
      tests_failed++;
      $display("FAIL undef_exit: got %0d want %0d", State, FETCH);
    end
`endif
  endtask

  // Random instruction stream, including illegal opcodes.
  task automatic test_random();
    logic [1:0] op;
    logic [5:0] f;
    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(3, 0));
      f  = 6'($urandom_range(63, 0));
      run_instr(op, f);
`ifdef MC_UNDEF_TRAP_EN
      if (op == 2'b11) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if (State !== 4'(FETCH)) begin
          tests_failed++;
          $display("FAIL random_undef_exit: got %0d want %0d", State, FETCH);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control unit for the multicycle ARM-subset datapath.
- Receives Op/Funct from the held instruction register.
- Sequences the multicycle state machine and issues per-state datapath enables and selects.
- Also produces the decode-side selects that feed the immediate extender (ImmSrc), the register-file port muxes (RegSrc) and the ALU (ALUControl, FlagW).

Parameters:
- STATE_W, 4, width of the state register; must hold all encodings in the shared package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; forces state to FETCH
- Op  input  2  Instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal
- Funct  input  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (for memory ops, [0]=L)
- IRWrite  output  1  instruction register load enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALU result
- ALUSrcA  output  1  0=register A, 1=PC
- ALUSrcB  output  2  00=register B, 01=ExtImm, 10=constant 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- NextPC  output  1  PC write for sequential fetch
- RegW  output  1  register-file write enable
- MemW  output  1  data-memory write enable
- Branch  output  1  PC write from branch target
- ImmSrc  output  2  to extender: 00 imm8 (rotated), 01 imm12, 10 imm24 branch
- RegSrc  output  2  [0]=1 forces Rn=PC (branch); [1]=1 reads Rd as 2nd source (STR)
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- FlagW  output  2  [1]=NZ write enable, [0]=CV write enable
- State  output  STATE_W  current state, for debug/bench

Behaviour:
- State is a single registered vector; every other output is a combinational Moore decode of State, Op and Funct. There are no output registers.
- Reset: State=FETCH on the first clock edge with reset=1. All outputs then take the FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0, RegW=MemW=Branch=0.
- Reset asserted in any state aborts the instruction. No write enable other than the FETCH ones may be asserted in the cycle following the reset edge.
- Transitions:
  - FETCH->DECODE.
  - DECODE->MEMADR when Op=01.
  - DECODE->EXECUTER when Op=00 and Funct[5]=0.
  - DECODE->EXECUTEI when Op=00 and Funct[5]=1.
  - DECODE->BRANCH when Op=10.
  - DECODE with Op=11: see Optional Feature.
  - MEMADR->MEMRD when Funct[0]=1, else MEMADR->MEMWR.
  - MEMRD->MEMWB->FETCH.
  - MEMWR->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH.
  - BRANCH->FETCH.
  - Any unencoded state->FETCH.
- Per-state outputs; unlisted outputs are 0:
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUSrcB=00.
  - EXECUTEI: ALUSrcB=01.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Instruction latency: branch 3 cycles; DP 4; STR 4; LDR 5.
- ImmSrc=Op in every state (value 11 is don't-care).
- RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
- ALU decode is active only in EXECUTER/EXECUTEI:
  - cmd 0100->00, 0010->01, 0000->10, 1100->11; any other cmd->00.
  - FlagW[1]=Funct[0].
  - FlagW[0]=Funct[0] and (cmd is ADD or SUB).
- In all other states ALUControl=00 (ADD for PC+4 / address / branch target) and FlagW=00.
- Op/Funct are sampled only in DECODE and later states. Their value during FETCH has no effect on transitions.

Optional Feature:
- Macro: MC_UNDEF_TRAP_EN.
- Defined: DECODE with Op=11 goes to state UNDEF.
  - UNDEF is absorbing until reset.
  - All enables are 0 in UNDEF; output Undef=1 (port present only when the macro is defined).
- Undefined: DECODE with Op=11 goes directly to FETCH, no writes occur, and there is no Undef port.

Decomposition:
- Shared package holds:
  - State encodings (FETCH=0 ... BRANCH=9, UNDEF=10).
  - ALUControl, ImmSrc, ResultSrc and ALUSrcB encodings.
  - Cmd constants (ADD/SUB/AND/ORR).
- One natural sub-module, alu_decoder: purely combinational, taking Funct and an ALUOp flag and producing ALUControl and FlagW.

Test Plan:
- ADD R1,R2,#5 (Op=00, Funct=101000) after reset -> States FETCH,DECODE,EXECUTEI,ALUWB,FETCH. Required: ImmSrc=00, ALUSrcB=01 and ALUControl=00 in EXECUTEI, FlagW=00, RegW=1 only in ALUWB.
- SUBS R3,R1,R2 (Op=00, Funct=000101) -> EXECUTER with ALUControl=01, FlagW=11. ORRS (Funct=011001) -> ALUControl=11, FlagW=10.
- LDR (Op=01, Funct=011001) -> MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1). Total 5 cycles, ImmSrc=01.
- STR (Op=01, Funct=011000) -> MEMWR with MemW=1, RegSrc=10, 4 cycles, RegW never 1.
- B (Op=10) -> BRANCH with Branch=1, ImmSrc=10, RegSrc=01, back to FETCH after 3 cycles.
- Reset pulsed during MEMWR, then Op=11 -> next State=FETCH with MemW=0. With MC_UNDEF_TRAP_EN: UNDEF held, Undef=1. Without it: FETCH on the cycle after DECODE.
